float_mul_issue_queue: RTL and testbench
========================================

Name: float_mul_issue_queue

Overview:
- Upstream feeder for float_mul_pipeline: buffers tagged operand pairs in a small FIFO.
- Issues them one at a time over the multiplier's req/ack handshake and captures each product into a tagged, valid/ready result register.
- Converts a bursty valid/ready producer into the single-outstanding req/ack protocol that float_mul_pipeline expects.

Parameters:
- float_width, 32, width of operands and product (IEEE-754 single).
- DEPTH, 4, operand FIFO entries; power of two, >= 2.
- TAG_WIDTH, 4, width of the user tag carried with each operation.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  FIFO can accept; equals (count != DEPTH).
- in_a  input  float_width  operand a.
- in_b  input  float_width  operand b.
- in_tag  input  TAG_WIDTH  tag returned with the result.
- mul_req  output  1  one-cycle request pulse to float_mul_pipeline.
- mul_a  output  float_width  operand a to multiplier; stable from req until ack.
- mul_b  output  float_width  operand b to multiplier; stable from req until ack.
- mul_ack  input  1  multiplier done pulse; mul_out valid in that cycle.
- mul_out  input  float_width  multiplier product.
- res_valid  output  1  result register full.
- res_ready  input  1  consumer accepts result.
- res_out  output  float_width  captured product.
- res_tag  output  TAG_WIDTH  tag of the captured product.
- count  output  $clog2(DEPTH+1)  FIFO occupancy.
- err  output  1  sticky: mul_ack seen outside WAIT.

Behaviour:
- Reset (async): count=0, rd/wr pointers=0, state=IDLE, mul_req=0, mul_a=mul_b=0, res_valid=0, res_out=0, res_tag=0, err=0. FIFO contents don't care.
- Reset mid-operation abandons the in-flight op and all queued entries. The multiplier shares rst.
- FIFO push when in_valid && in_ready. in_ready is derived from registered count only: when full, no push even in a pop cycle. Pointers wrap modulo DEPTH.
- Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE: if count != 0 and !res_valid:
  - pop head into mul_a/mul_b/cur_tag;
  - mul_req<=1;
  - ->WAIT.
  - Otherwise hold.
- WAIT:
  - mul_req<=0 (req is high exactly the first WAIT cycle).
  - mul_ack is honoured in any WAIT cycle, including the first.
  - On mul_ack: res_out<=mul_out, res_tag<=cur_tag, res_valid<=1, ->DRAIN.
  - mul_a/mul_b are not modified while in WAIT.
- DRAIN: on res_valid && res_ready: res_valid<=0, ->IDLE.
- Result is held unchanged while res_ready is low.
- Exactly one multiplier op is outstanding at any time. Results return in FIFO order.
- Latency, empty queue: entry pushed at edge E -> mul_req high after edge E+1. mul_ack at edge K -> res_valid high after edge K. Accepted at edge R -> next mul_req high after edge R+1 if FIFO is non-empty.
- mul_ack in IDLE or DRAIN: ignored for data (result unchanged) and err<=1. err clears only on rst.
- No arithmetic on float data; values pass through bit-exact.
- Producer may push while an op is in flight or a result is blocked. The FIFO absorbs up to DEPTH entries; in_ready=0 when full.

Test Plan:
- Single op, real float_mul_pipeline: push a=0x3F99999A (1.2), b=0x40600000 (3.5), tag=3, res_ready=1 -> one mul_req pulse, res_valid with res_out within 1e-6 relative of 4.2 (≈0x40866666), res_tag=3, err=0.
- Burst of 5 with res_ready=1, DEPTH=4: push (100.0,4.5,t0), (2.0,2.0,t1), (-2000.0,2.3,t2), (0.0,1.0,t3), (8.0,4.0,t4). in_ready drops while 4 are queued. Results in order: 0x43E10000 (450) t0, 0x40800000 (4) t1, ≈-4600 t2, 0x00000000 t3, 0x42000000 (32) t4.
- Backpressure: hold res_ready=0 for 20 cycles after the first result -> res_out/res_tag stable, no further mul_req, count reaches 4 with in_ready=0. Release -> remaining results drain in order.
- Stub multiplier, ack in the same cycle as req -> result captured; mul_a/mul_b never change between req and ack. Stub with 7-cycle ack -> mul_req high exactly 1 cycle.
- Spurious mul_ack in IDLE -> err=1 and stays set; res_valid unchanged; subsequent ops complete correctly.
- Assert rst while in WAIT with 3 entries queued -> all outputs return to their reset values immediately (count=0, res_valid=0, mul_req=0). After release, a new push completes normally.

Source files
------------

// File: rtl/float_mul_issue_queue.sv
// Operand FIFO feeding a single-outstanding req/ack multiplier, with a tagged
// valid/ready result register on the output side.
module float_mul_issue_queue #(
  parameter int unsigned float_width = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TAG_WIDTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [float_width-1:0]       in_a,
  input  logic [float_width-1:0]       in_b,
  input  logic [TAG_WIDTH-1:0]         in_tag,
  output logic                         mul_req,
  output logic [float_width-1:0]       mul_a,
  output logic [float_width-1:0]       mul_b,
  input  logic                         mul_ack,
  input  logic [float_width-1:0]       mul_out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [float_width-1:0]       res_out,
  output logic [TAG_WIDTH-1:0]         res_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StDrain} state_e;

  state_e state_q, state_d;

  logic [float_width-1:0] mem_a   [DEPTH];
  logic [float_width-1:0] mem_b   [DEPTH];
  logic [TAG_WIDTH-1:0]   mem_tag [DEPTH];

  logic [PtrW-1:0]      wr_ptr, rd_ptr;
  logic [CntW-1:0]      count_d;
  logic [TAG_WIDTH-1:0] cur_tag;
  logic                 push, pop, capture, accept;

  // in_ready comes from the registered count only, so a full FIFO refuses a
  // push even in a cycle where it also pops.
  assign in_ready = (count != Full);
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == StIdle) && (count != '0) && !res_valid;
  assign capture  = (state_q == StWait) && mul_ack;
  assign accept   = (state_q == StDrain) && res_valid && res_ready;

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + CntW'(1);
      2'b01:   count_d = count - CntW'(1);
      default: count_d = count;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pop) state_d = StWait;
      StWait:  if (mul_ack) state_d = StDrain;
      StDrain: if (res_valid && res_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage has no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      mul_req   <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      cur_tag   <= '0;
      res_valid <= 1'b0;
      res_out   <= '0;
      res_tag   <= '0;
      err       <= 1'b0;
    end else begin
      count <= count_d;
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      // A pop is the only way into WAIT, so req is high exactly one cycle.
      mul_req <= pop;
      if (pop) begin
        rd_ptr  <= rd_ptr + PtrW'(1);
        mul_a   <= mem_a[rd_ptr];
        mul_b   <= mem_b[rd_ptr];
        cur_tag <= mem_tag[rd_ptr];
      end
      if (capture) begin
        res_out   <= mul_out;
        res_tag   <= cur_tag;
        res_valid <= 1'b1;
      end else if (accept) begin
        res_valid <= 1'b0;
      end
      if (mul_ack && (state_q != StWait)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_float_mul_issue_queue.sv
// Directed bench for float_mul_issue_queue with a latency-programmable stub
// multiplier and a result monitor.
module tb_float_mul_issue_queue;

  localparam int unsigned FW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TW    = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [FW-1:0] in_a, in_b;
  logic [TW-1:0] in_tag;
  logic          mul_req;
  logic [FW-1:0] mul_a, mul_b;
  logic          mul_ack;
  logic [FW-1:0] mul_out;
  logic          res_valid, res_ready;
  logic [FW-1:0] res_out;
  logic [TW-1:0] res_tag;
  logic [CW-1:0] count;
  logic          err;

  float_mul_issue_queue #(.float_width(FW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_ack(mul_ack), .mul_out(mul_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out), .res_tag(res_tag),
    .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp_out;
    logic [3:0]  exp_tag;
  } vec_t;

  vec_t        vecs[6];
  logic [35:0] res_q[$];
  int          checks, errors;
  int          lat, spur_req;
  int          spur_done, req_cnt, req_long, stable_viol, overlap_viol;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hand-rounded single-precision products for the operand pairs used here.
  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F99999A, 32'h40600000}: prod = 32'h40866667;
      {32'h42C80000, 32'h40900000}: prod = 32'h43E10000;
      {32'h40000000, 32'h40000000}: prod = 32'h40800000;
      {32'hC4FA0000, 32'h40133333}: prod = 32'hC58FC000;
      {32'h00000000, 32'h3F800000}: prod = 32'h00000000;
      {32'h41000000, 32'h40800000}: prod = 32'h42000000;
      default:                      prod = a ^ b;
    endcase
  endfunction

  // Stub multiplier: acks `lat` cycles after seeing req, watches operand stability.
  initial begin : stub
    logic        pending, prev_req;
    logic [31:0] cap_a, cap_b;
    int          cnt;
    pending = 0; prev_req = 0; cap_a = '0; cap_b = '0; cnt = 0;
    spur_done = 0; req_cnt = 0; req_long = 0; stable_viol = 0; overlap_viol = 0;
    mul_ack = 1'b0; mul_out = '0;
    forever begin
      @(posedge clk); #1;
      mul_ack = 1'b0;
      if (rst) begin
        pending = 0; prev_req = 0;
      end else begin
        if (mul_req) begin
          if (prev_req) req_long++;
          else begin
            req_cnt++;
            if (pending) overlap_viol++;
          end
          pending = 1; cap_a = mul_a; cap_b = mul_b; cnt = lat;
        end else if (pending && (mul_a !== cap_a || mul_b !== cap_b)) begin
          stable_viol++;
        end
        prev_req = mul_req;
        if (pending) begin
          if (cnt == 0) begin
            mul_ack = 1'b1; mul_out = prod(cap_a, cap_b); pending = 0;
          end else cnt--;
        end else if (spur_done != spur_req) begin
          mul_ack = 1'b1; mul_out = 32'hFFFFFFFF; spur_done++;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst && res_valid && res_ready) res_q.push_back({res_tag, res_out});
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_tag = tag;
    for (int n = 0; n < 300 && !ok; n++) begin
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("push_accepted", 64'(ok), 64'(1));
  endtask

  task automatic push_vec(input int i);
    push(vecs[i].a, vecs[i].b, vecs[i].tag);
  endtask

  task automatic wait_results(input int n);
    for (int k = 0; k < 400 && res_q.size() < n; k++) begin
      @(posedge clk); #1;
    end
    check("result_count", 64'(res_q.size()), 64'(n));
  endtask

  task automatic check_result(input int idx, input int v);
    if (idx < res_q.size()) begin
      check("res_out", 64'(res_q[idx][31:0]), 64'(vecs[v].exp_out));
      check("res_tag", 64'(res_q[idx][35:32]), 64'(vecs[v].exp_tag));
    end else begin
      check("res_present", 64'(res_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin : main
    int          n0, r0, bad;
    logic [31:0] hold_out;
    logic [3:0]  hold_tag;
    checks = 0; errors = 0; lat = 3; spur_req = 0;
    vecs[0] = '{a: 32'h3F99999A, b: 32'h40600000, tag: 4'd3, exp_out: 32'h40866667, exp_tag: 4'd3};
    vecs[1] = '{a: 32'h42C80000, b: 32'h40900000, tag: 4'd0, exp_out: 32'h43E10000, exp_tag: 4'd0};
    vecs[2] = '{a: 32'h40000000, b: 32'h40000000, tag: 4'd1, exp_out: 32'h40800000, exp_tag: 4'd1};
    vecs[3] = '{a: 32'hC4FA0000, b: 32'h40133333, tag: 4'd2, exp_out: 32'hC58FC000, exp_tag: 4'd2};
    vecs[4] = '{a: 32'h00000000, b: 32'h3F800000, tag: 4'd3, exp_out: 32'h00000000, exp_tag: 4'd3};
    vecs[5] = '{a: 32'h41000000, b: 32'h40800000, tag: 4'd4, exp_out: 32'h42000000, exp_tag: 4'd4};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_mul_req", 64'(mul_req), 64'(0));
    check("rst_mul_a", 64'(mul_a), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_res_out", 64'(res_out), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Single op and first-request latency.
    n0 = res_q.size(); r0 = req_cnt;
    push_vec(0);
    check("lat_count", 64'(count), 64'(1));
    check("lat_req_early", 64'(mul_req), 64'(0));
    @(posedge clk); #1;
    check("lat_req", 64'(mul_req), 64'(1));
    check("lat_mul_a", 64'(mul_a), 64'(vecs[0].a));
    check("lat_mul_b", 64'(mul_b), 64'(vecs[0].b));
    wait_results(n0 + 1);
    check_result(n0, 0);
    check("single_reqs", 64'(req_cnt - r0), 64'(1));
    check("single_err", 64'(err), 64'(0));

    // Burst of five: FIFO fills to DEPTH while the first op is in flight.
    lat = 7; n0 = res_q.size(); r0 = req_cnt;
    for (int i = 1; i <= 5; i++) push_vec(i);
    check("burst_full_count", 64'(count), 64'(4));
    check("burst_in_ready", 64'(in_ready), 64'(0));
    wait_results(n0 + 5);
    for (int i = 0; i < 5; i++) check_result(n0 + i, i + 1);
    check("burst_reqs", 64'(req_cnt - r0), 64'(5));

    // Backpressure on the result register.
    lat = 2; res_ready = 1'b0; n0 = res_q.size(); r0 = req_cnt;
    for (int i = 1; i <= 5; i++) push_vec(i);
    for (int k = 0; k < 100 && !res_valid; k++) begin
      @(posedge clk); #1;
    end
    check("bp_res_valid", 64'(res_valid), 64'(1));
    check("bp_first_out", 64'(res_out), 64'(vecs[1].exp_out));
    check("bp_first_tag", 64'(res_tag), 64'(vecs[1].exp_tag));
    hold_out = res_out; hold_tag = res_tag; bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (res_out !== hold_out || res_tag !== hold_tag || res_valid !== 1'b1) bad++;
    end
    check("bp_hold_stable", 64'(bad), 64'(0));
    check("bp_no_req", 64'(req_cnt - r0), 64'(1));
    check("bp_count", 64'(count), 64'(4));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    res_ready = 1'b1;
    wait_results(n0 + 5);
    for (int i = 0; i < 5; i++) check_result(n0 + i, i + 1);

    // Ack in the same cycle as req.
    lat = 0; n0 = res_q.size();
    push_vec(3);
    push_vec(5);
    wait_results(n0 + 2);
    check_result(n0, 3);
    check_result(n0 + 1, 5);

    // Slow ack: req must still be a single-cycle pulse.
    lat = 7; n0 = res_q.size(); r0 = req_cnt;
    push_vec(2);
    wait_results(n0 + 1);
    check_result(n0, 2);
    check("slow_reqs", 64'(req_cnt - r0), 64'(1));
    check("req_long", 64'(req_long), 64'(0));
    check("operand_stable", 64'(stable_viol), 64'(0));
    check("single_outstanding", 64'(overlap_viol), 64'(0));
    check("err_before_spur", 64'(err), 64'(0));

    // Spurious ack while idle.
    repeat (3) @(posedge clk);
    #1;
    spur_req = 1;
    repeat (3) @(posedge clk);
    #1;
    check("spur_err", 64'(err), 64'(1));
    check("spur_res_valid", 64'(res_valid), 64'(0));
    check("spur_res_out", 64'(res_out), 64'(vecs[2].exp_out));
    lat = 1; n0 = res_q.size();
    push_vec(1);
    wait_results(n0 + 1);
    check_result(n0, 1);
    check("spur_err_sticky", 64'(err), 64'(1));

    // Reset while waiting with three entries queued.
    lat = 50;
    for (int i = 1; i <= 4; i++) push_vec(i);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_count", 64'(count), 64'(3));
    check("pre_rst_req", 64'(mul_req), 64'(0));
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", 64'(count), 64'(0));
    check("async_rst_res_valid", 64'(res_valid), 64'(0));
    check("async_rst_mul_req", 64'(mul_req), 64'(0));
    check("async_rst_mul_a", 64'(mul_a), 64'(0));
    check("async_rst_err", 64'(err), 64'(0));
    check("async_rst_in_ready", 64'(in_ready), 64'(1));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 2; n0 = res_q.size();
    @(posedge clk); #1;
    push_vec(5);
    wait_results(n0 + 1);
    check_result(n0, 5);
    check("post_rst_count", 64'(count), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
